// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the data SRAM controller: FSM states, mem_sel codes
// and the byte-enable lookup used when a write is accepted.
package data_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RACC   = 3'd1,
    ST_RDONE  = 3'd2,
    ST_WSETUP = 3'd3,
    ST_WPULSE = 3'd4,
    ST_WHOLD  = 3'd5,
    ST_WDONE  = 3'd6
  } state_t;

  localparam logic [1:0] MS_NONE = 2'b00;
  localparam logic [1:0] MS_BYTE = 2'b01;
  localparam logic [1:0] MS_HALF = 2'b10;
  localparam logic [1:0] MS_WORD = 2'b11;

  // Active-low byte enables; data is low-lane aligned so narrow writes use lane 0 upward.
  function automatic logic [3:0] be_n_for(input logic [1:0] sel);
    case (sel)
      MS_BYTE: be_n_for = 4'b1110;
      MS_HALF: be_n_for = 4'b1100;
      MS_WORD: be_n_for = 4'b0000;
      default: be_n_for = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_ctrl.sv
// Data-memory responder for the MEM stage: runs level-requested reads/writes on a
// 32-bit SRAM (two 16-bit halves) with fully registered strobes and completion flags.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_ce,
  input  logic              write_ce,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  input  logic [1:0]        mem_sel,
  output logic [31:0]       rom_rdata,
  output logic              rfin_a,
  output logic              rfin_b,
  output logic              wfin_a,
  output logic              wfin_b,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rfin;
  logic             r_wfin;
  logic             w_unused_addr;

  assign w_unused_addr = ^address[31:ADDR_W];

  assign rfin_a = r_rfin;
  assign rfin_b = r_rfin;
  assign wfin_a = r_wfin;
  assign wfin_b = r_wfin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rfin     <= 1'b0;
      r_wfin     <= 1'b0;
      rom_rdata  <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rfin <= 1'b0;
          r_wfin <= 1'b0;
          r_cnt  <= '0;
          // Write wins a simultaneous request; a write with no lanes is dropped.
          if (write_ce && mem_sel != MS_NONE) begin
            r_state    <= ST_WSETUP;
            sram_addr  <= address[ADDR_W-1:0];
            sram_dq_o  <= wdata;
            sram_be_n  <= be_n_for(mem_sel);
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b1;
          end else if (read_ce) begin
            r_state    <= ST_RACC;
            sram_addr  <= address[ADDR_W-1:0];
            sram_be_n  <= 4'b0000;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end
        end
        ST_RACC: begin
          if (!read_ce) begin
            r_state   <= ST_IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= ST_RDONE;
            rom_rdata <= sram_dq_i;
            r_rfin    <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RDONE: begin
          if (!read_ce) begin
            r_state <= ST_IDLE;
            r_rfin  <= 1'b0;
          end
        end
        ST_WSETUP: begin
          r_state   <= ST_WPULSE;
          r_cnt     <= '0;
          sram_we_n <= 1'b0;
        end
        // The pulse and hold always run to completion so the SRAM never sees a torn write.
        ST_WPULSE: begin
          if (r_cnt == CNT_LAST) begin
            r_state   <= ST_WHOLD;
            sram_we_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WHOLD: begin
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          if (write_ce) begin
            r_state <= ST_WDONE;
            r_wfin  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WDONE: begin
          if (!write_ce) begin
            r_state <= ST_IDLE;
            r_wfin  <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl with default parameters (ADDR_W=20, WAIT_CYCLES=1).
module tb_data_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_ce;
  logic        write_ce;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [1:0]  mem_sel;
  logic [31:0] rom_rdata;
  logic        rfin_a, rfin_b, wfin_a, wfin_b;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_i;

  int n_pass  = 0;
  int n_total = 0;

  data_sram_ctrl #(.ADDR_W(20), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .read_ce(read_ce), .write_ce(write_ce),
    .address(address), .wdata(wdata), .mem_sel(mem_sel),
    .rom_rdata(rom_rdata), .rfin_a(rfin_a), .rfin_b(rfin_b),
    .wfin_a(wfin_a), .wfin_b(wfin_b), .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus-contention guard over every scenario while out of reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_total++;
      assert (!(sram_oe_n === 1'b0 && sram_dq_oe === 1'b1)) n_pass++;
      else $error("FAIL contention: observed oe_n=%b dq_oe=%b expected not 0/1", sram_oe_n, sram_dq_oe);
    end
  end

  initial begin
    rst = 1'b0; read_ce = 1'b0; write_ce = 1'b0;
    address = '0; wdata = '0; mem_sel = 2'b00; sram_dq_i = '0;
    tick(); tick();
    check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_be_n", {28'd0, sram_be_n}, 32'hF);
    check("rst_addr", {12'd0, sram_addr}, 32'd0);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_rdata", rom_rdata, 32'd0);
    check("rst_fins", {28'd0, rfin_a, rfin_b, wfin_a, wfin_b}, 32'd0);
    rst = 1'b1;
    tick();

    // Word read
    address = 32'h0000_0123; mem_sel = 2'b11; sram_dq_i = 32'hDEADBEEF; read_ce = 1'b1;
    tick();
    check("rd_addr", {12'd0, sram_addr}, 32'h00123);
    check("rd_c0_strobes", {30'd0, sram_ce_n, sram_oe_n}, 32'd0);
    check("rd_c0_be", {28'd0, sram_be_n}, 32'd0);
    check("rd_c0_rfin", {31'd0, rfin_a}, 32'd0);
    tick();
    check("rd_c1_strobes", {30'd0, sram_ce_n, sram_oe_n}, 32'd0);
    check("rd_c1_rfin", {31'd0, rfin_a}, 32'd0);
    tick();
    check("rd_rdata", rom_rdata, 32'hDEADBEEF);
    check("rd_rfin", {30'd0, rfin_a, rfin_b}, 32'd3);
    check("rd_release", {30'd0, sram_ce_n, sram_oe_n}, 32'd3);
    tick(); tick();
    check("rd_rfin_held", {30'd0, rfin_a, rfin_b}, 32'd3);
    read_ce = 1'b0;
    tick();
    check("rd_rfin_clear", {30'd0, rfin_a, rfin_b}, 32'd0);

    // Byte write
    address = 32'h10; wdata = 32'h000000A5; mem_sel = 2'b01; write_ce = 1'b1;
    tick();
    check("wb_setup_be", {28'd0, sram_be_n}, 32'hE);
    check("wb_setup_dq", sram_dq_o, 32'h000000A5);
    check("wb_setup_addr", {12'd0, sram_addr}, 32'h10);
    check("wb_setup_ctl", {28'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b0111);
    tick();
    check("wb_pulse1_we", {31'd0, sram_we_n}, 32'd0);
    tick();
    check("wb_pulse2_we", {31'd0, sram_we_n}, 32'd0);
    tick();
    check("wb_hold_ctl", {28'd0, sram_ce_n, sram_we_n, sram_dq_oe, wfin_a}, 32'b0110);
    tick();
    check("wb_wfin", {30'd0, wfin_a, wfin_b}, 32'd3);
    check("wb_done_ctl", {30'd0, sram_ce_n, sram_dq_oe}, 32'b10);
    tick();
    check("wb_wfin_held", {30'd0, wfin_a, wfin_b}, 32'd3);
    write_ce = 1'b0;
    tick();
    check("wb_wfin_clear", {30'd0, wfin_a, wfin_b}, 32'd0);

    // Simultaneous read and write: write only
    address = 32'h55; wdata = 32'h12345678; mem_sel = 2'b11; read_ce = 1'b1; write_ce = 1'b1;
    tick();
    check("both_setup", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, 1'b0}, 32'b01110);
    check("both_be", {28'd0, sram_be_n}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("both_no_oe", {31'd0, sram_oe_n}, 32'd1);
    end
    tick();
    check("both_fins", {28'd0, wfin_a, wfin_b, rfin_a, rfin_b}, 32'b1100);
    read_ce = 1'b0; write_ce = 1'b0;
    tick();
    check("both_clear", {28'd0, wfin_a, wfin_b, rfin_a, rfin_b}, 32'd0);
    tick();
    check("both_idle", {31'd0, sram_ce_n}, 32'd1);

    // write_ce dropped during the pulse
    address = 32'h20; wdata = 32'h0000BEEF; mem_sel = 2'b10; write_ce = 1'b1;
    tick(); tick();
    check("wd_pulse_we", {31'd0, sram_we_n}, 32'd0);
    check("wd_be", {28'd0, sram_be_n}, 32'hC);
    write_ce = 1'b0;
    tick();
    check("wd_pulse2_we", {31'd0, sram_we_n}, 32'd0);
    tick();
    check("wd_hold", {29'd0, sram_ce_n, sram_we_n, sram_dq_oe}, 32'b011);
    tick();
    check("wd_idle", {28'd0, sram_ce_n, sram_dq_oe, wfin_a, wfin_b}, 32'b1000);

    // read_ce dropped during access
    address = 32'h7; mem_sel = 2'b11; sram_dq_i = 32'h11111111; read_ce = 1'b1;
    tick();
    check("rd_abort_acc", {31'd0, sram_oe_n}, 32'd0);
    read_ce = 1'b0;
    tick();
    check("rd_abort_idle", {29'd0, sram_ce_n, sram_oe_n, rfin_a}, 32'b110);
    check("rd_abort_rdata", rom_rdata, 32'hDEADBEEF);
    tick(); tick();
    check("rd_abort_stays", {29'd0, sram_ce_n, rfin_a, rfin_b}, 32'b100);

    // Async reset in the middle of a write pulse
    address = 32'h30; wdata = 32'hCAFEF00D; mem_sel = 2'b11; write_ce = 1'b1;
    tick(); tick();
    check("rs_pulse_we", {31'd0, sram_we_n}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rs_ctl", {29'd0, sram_we_n, sram_ce_n, sram_dq_oe}, 32'b110);
    check("rs_rdata", rom_rdata, 32'd0);
    check("rs_fins", {28'd0, rfin_a, rfin_b, wfin_a, wfin_b}, 32'd0);
    write_ce = 1'b0;
    #1 rst = 1'b1;
    tick();

    // Write with no lanes selected is ignored
    address = 32'h40; wdata = 32'hFFFFFFFF; mem_sel = 2'b00; write_ce = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ms0_quiet", {28'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b1110);
    end
    check("ms0_nofin", {30'd0, wfin_a, wfin_b}, 32'd0);
    write_ce = 1'b0;

    // Read with mem_sel=00 still runs as a full word
    address = 32'h9; sram_dq_i = 32'h0BADF00D; read_ce = 1'b1;
    tick();
    check("rd0_strobes", {30'd0, sram_ce_n, sram_oe_n}, 32'd0);
    check("rd0_be", {28'd0, sram_be_n}, 32'd0);
    tick(); tick();
    check("rd0_rdata", rom_rdata, 32'h0BADF00D);
    check("rd0_rfin", {30'd0, rfin_a, rfin_b}, 32'd3);
    read_ce = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_sram_ctrl.md
Name: data_sram_ctrl

Overview:
- Responder for the MEM stage's data-memory request interface: accepts level requests `read_ce`/`write_ce` with word address, `wdata` and `mem_sel`.
- Runs the access on the external data SRAM, built as two 16-bit halves (lo = bits 15:0, hi = bits 31:16) sharing ce/oe/we/addr.
- Returns `rom_rdata` and the completion flags `rfin_a`/`rfin_b`/`wfin_a`/`wfin_b` that the MEM stage waits on.
- Sits between the MEM stage and the top-level SRAM tristate pads.

Parameters:
- ADDR_W, 20, SRAM word-address width; address bits above ADDR_W-1 are ignored.
- WAIT_CYCLES, 1, extra access cycles; read access and write-pulse phases each last WAIT_CYCLES+1 cycles.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- read_ce  in  1  read request, level, held by requester until it drops it.
- write_ce  in  1  write request, level, held by requester until it drops it.
- address  in  32  word address ({2'b00, byte_addr[31:2]}).
- wdata  in  32  write data, low-lane aligned.
- mem_sel  in  2  01 byte, 10 half, 11 word, 00 no access.
- rom_rdata  out  32  registered raw read word.
- rfin_a, rfin_b  out  1  read complete, lo/hi half; always equal.
- wfin_a, wfin_b  out  1  write complete, lo/hi half; always equal.
- sram_addr  out  ADDR_W  SRAM address.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes, active-low.
- sram_be_n  out  4  byte enables, active-low; [1:0] lo chip, [3:2] hi chip.
- sram_dq_o  out  32  write data to pads.
- sram_dq_oe  out  1  pad output enable (1 = drive).
- sram_dq_i  in  32  read data from pads.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_be_n=4'hF
  - sram_addr=0, sram_dq_o=0, sram_dq_oe=0
  - rom_rdata=0, all fin flags 0
- Reset mid-operation aborts immediately; the SRAM write may be lost. All outputs are registered.
- States: IDLE, RACC, RDONE, WSETUP, WPULSE, WHOLD, WDONE. A counter of width clog2(WAIT_CYCLES+1) times RACC and WPULSE.
- IDLE:
  - write_ce=1 and mem_sel!=00 → WSETUP. Latch address[ADDR_W-1:0], wdata, be_n.
  - else read_ce=1 → RACC.
  - Write has priority if both requests are high.
  - read_ce with mem_sel=00 is still performed (full word). write_ce with mem_sel=00 is ignored and stays IDLE.
- be_n by mem_sel: 01→4'b1110, 10→4'b1100, 11→4'b0000. Reads always use 4'b0000.
- RACC, WAIT_CYCLES+1 cycles:
  - ce_n=0, oe_n=0, dq_oe=0.
  - On the last cycle's edge, capture sram_dq_i into rom_rdata → RDONE.
  - If read_ce drops during RACC → IDLE next edge, no fin, rom_rdata unchanged.
- RDONE:
  - rfin_a=rfin_b=1, strobes released (ce_n=oe_n=1).
  - Held while read_ce=1; read_ce=0 → IDLE, fins cleared.
- Read latency: rfin rises WAIT_CYCLES+1 edges after the accepting edge (default 2).
- WSETUP, 1 cycle: ce_n=0, we_n=1, dq_oe=1, dq_o=latched wdata.
- WPULSE, WAIT_CYCLES+1 cycles: we_n=0.
- WHOLD, 1 cycle: we_n=1, data still driven.
- WDONE:
  - wfin_a=wfin_b=1, ce_n=1, dq_oe=0.
  - Held while write_ce=1; write_ce=0 → IDLE.
- Write latency: wfin rises WAIT_CYCLES+3 edges after the accepting edge (default 4).
- A write always completes through WHOLD even if write_ce drops (no torn SRAM write). It then goes to IDLE directly, with no fin.
- Back-to-back requests:
  - A new request is accepted only from IDLE.
  - The requester must drop ce for at least one cycle between accesses; fins are cleared that cycle.
- dq_oe is never 1 while oe_n=0 (no bus contention). oe_n=1 in every write state.

Decomposition:
- Shared package: state encoding, mem_sel constants (MS_NONE/BYTE/HALF/WORD), be_n lookup function.
- No sub-module needed; a single FSM plus counter.
- The pad tristate (dq = dq_oe ? dq_o : 'z) lives in the top level.

Test Plan:
- Word read, address=0x0000_0123, sram_dq_i=0xDEADBEEF:
  - sram_addr=0x00123, ce_n=oe_n=0 for 2 cycles.
  - rom_rdata=0xDEADBEEF and rfin_a=rfin_b=1 two edges after accept.
  - Fins held until read_ce=0.
- Byte write, mem_sel=01, wdata=0x000000A5, address=0x10:
  - be_n=4'b1110, dq_o=0x000000A5, dq_oe=1.
  - we_n low exactly 2 cycles, flanked by 1 setup and 1 hold cycle.
  - wfin 4 edges after accept.
- read_ce and write_ce high together (mem_sel=11): write performed first, no read strobes, wfin only.
- write_ce dropped during WPULSE: we_n/WHOLD sequence completes unchanged, no wfin, returns to IDLE. read_ce dropped in RACC: IDLE next edge, rom_rdata unchanged.
- rst low mid-WPULSE: asynchronously we_n=1, ce_n=1, dq_oe=0, rom_rdata=0, fins 0.
- write_ce with mem_sel=00: no SRAM strobe activity; stays IDLE for 10 cycles.
- Throughout all scenarios: assertion that oe_n=0 and dq_oe=1 never occur together.
